// File: rtl/dct_pkg.sv
// Shared definitions for the DCT coefficient engine: default geometry,
// controller state encoding and accumulator sizing.
package dct_pkg;

  localparam int DEF_N        = 8;
  localparam int DEF_PIX_W    = 8;
  localparam int DEF_C_FRAC   = 15;
  localparam int DEF_OUT_FRAC = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Pixel * Q(OUT_FRAC) cos_term, summed over N*N samples without overflow.
  function automatic int acc_width(input int pix_w, input int out_frac, input int n);
    return pix_w + out_frac + 2 + 2 * $clog2(n);
  endfunction

endpackage

// File: rtl/dct_cos_1d_rom.sv
// 1D cosine ROM: coef = round(cos((2n+1)k*pi/2N) * 2^C_FRAC), built at elaboration.
module dct_cos_1d_rom
  import dct_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int C_FRAC = DEF_C_FRAC
) (
  input  logic [$clog2(N)-1:0]  k,
  input  logic [$clog2(N)-1:0]  n,
  output logic signed [C_FRAC+1:0] coef
);

  typedef logic signed [C_FRAC+1:0] entry_t;

  localparam real PI = 3.14159265358979323846;

  // Round half away from zero so the table is symmetric in sign.
  function automatic entry_t cos_entry(input int kk, input int nn);
    real x;
    int  v;
    x = $cos((2.0 * nn + 1.0) * kk * PI / (2.0 * N)) * real'(1 << C_FRAC);
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    return entry_t'(v);
  endfunction

  entry_t rom_tbl [N*N];

  for (genvar gk = 0; gk < N; gk++) begin : g_k
    for (genvar gn = 0; gn < N; gn++) begin : g_n
      localparam entry_t VAL = cos_entry(gk, gn);
      assign rom_tbl[gk*N+gn] = VAL;
    end
  end

  assign coef = rom_tbl[{k, n}];

endmodule

// File: rtl/dct_coeff_engine.sv
// Sequential 2D DCT coefficient engine: streams an N x N block from the pixel
// buffer and accumulates F(k1,k2). Build option DCT_RES_SAT_EN saturates the result.
module dct_coeff_engine
  import dct_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int PIX_W    = DEF_PIX_W,
  parameter int C_FRAC   = DEF_C_FRAC,
  parameter int OUT_FRAC = DEF_OUT_FRAC,
  parameter int RES_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(N)-1:0]       k1,
  input  logic [$clog2(N)-1:0]       k2,
  output logic                       busy,
  output logic                       pix_re,
  output logic [2*$clog2(N)-1:0]     pix_addr,
  input  logic signed [PIX_W-1:0]    pix_rdata,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [RES_W-1:0]    res_data
);

  localparam int IW    = $clog2(N);
  localparam int AW    = 2 * IW;
  localparam int CW    = C_FRAC + 2;
  localparam int TW    = OUT_FRAC + 2;
  localparam int PW    = PIX_W + TW;
  localparam int ACC_W = acc_width(PIX_W, OUT_FRAC, N);
  localparam int SHIFT = 2 * C_FRAC - OUT_FRAC;

  localparam logic [AW-1:0]             LAST = '1;
  localparam logic signed [2*CW-1:0]    BIAS = {{(2*CW-SHIFT){1'b0}}, {SHIFT{1'b1}}};

  // Adding 2^SHIFT-1 to negative products turns the arithmetic shift into
  // truncation toward zero, matching the legacy Q8 tables.
  function automatic logic signed [TW-1:0] cos_term_f(input logic signed [CW-1:0] a,
                                                     input logic signed [CW-1:0] b);
    logic signed [2*CW-1:0] p;
    logic signed [2*CW-1:0] q;
    p = (2*CW)'(a) * (2*CW)'(b);
    if (p < 0) p = p + BIAS;
    q = p >>> SHIFT;
    return q[TW-1:0];
  endfunction

`ifdef DCT_RES_SAT_EN
  localparam int EXT_W = ((ACC_W > RES_W) ? ACC_W : RES_W) + 1;
  localparam logic signed [EXT_W-1:0] RES_MAX = EXT_W'({1'b0, {(RES_W-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] RES_MIN = -RES_MAX - EXT_W'(1);

  function automatic logic signed [RES_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
    logic signed [EXT_W-1:0] w;
    w = EXT_W'(v);
    if (w > RES_MAX)      return RES_MAX[RES_W-1:0];
    else if (w < RES_MIN) return RES_MIN[RES_W-1:0];
    else                  return w[RES_W-1:0];
  endfunction
`else
  function automatic logic signed [RES_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
    return RES_W'(v);
  endfunction
`endif

  state_t                  state, state_nxt;
  logic [IW-1:0]           k1_q, k2_q;
  logic [1:0]              drain_cnt;
  logic                    issue;
  logic                    rd_vld, vld_p0, vld_p1;
  logic [AW-1:0]           addr_q;
  logic signed [CW-1:0]    c_row, c_col;
  logic signed [PIX_W-1:0] pix_p0;
  logic signed [TW-1:0]    cos_p0;
  logic signed [PW-1:0]    prod_p1;
  logic signed [ACC_W-1:0] acc;

  dct_cos_1d_rom #(.N(N), .C_FRAC(C_FRAC)) u_rom_row (
    .k    (k1_q),
    .n    (addr_q[AW-1:IW]),
    .coef (c_row)
  );

  dct_cos_1d_rom #(.N(N), .C_FRAC(C_FRAC)) u_rom_col (
    .k    (k2_q),
    .n    (addr_q[IW-1:0]),
    .coef (c_col)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // RUN ends once the final address strobe is on the bus; DRAIN covers the
  // remaining read-return and pipeline cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (pix_re && pix_addr == LAST) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign issue = (state == RUN) && !(pix_re && pix_addr == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k1_q      <= '0;
      k2_q      <= '0;
      pix_re    <= 1'b0;
      pix_addr  <= '0;
      drain_cnt <= 2'd0;
      rd_vld    <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      acc       <= '0;
    end else begin
      if (state == IDLE && start) begin
        k1_q <= k1;
        k2_q <= k2;
      end
      pix_re    <= issue;
      pix_addr  <= issue ? (pix_re ? pix_addr + AW'(1) : '0) : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      rd_vld    <= pix_re;
      vld_p0    <= rd_vld;
      vld_p1    <= vld_p0;
      // stage p2: accumulate
      if (state == IDLE && start) acc <= '0;
      else if (vld_p1)            acc <= acc + ACC_W'(prod_p1);
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= pix_addr;
    // stage p0: pixel and 2D cos_term
    pix_p0  <= pix_rdata;
    cos_p0  <= cos_term_f(c_row, c_col);
    // stage p1: product
    prod_p1 <= PW'(pix_p0) * PW'(cos_p0);
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign res_data  = narrow(acc);

endmodule

// File: tb/tb_dct_coeff_engine.sv
// Self-checking bench for dct_coeff_engine: directed test-plan cases plus
// randomized blocks against a floating-point-derived reference.
module tb_dct_coeff_engine;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, res_ready;
  logic [2:0]         k1, k2;
  logic               busy, pix_re, res_valid;
  logic [5:0]         pix_addr;
  logic signed [7:0]  pix_rdata;
  logic signed [31:0] res_data;

  logic               start16, res_ready16;
  logic               busy16, pix_re16, res_valid16;
  logic [5:0]         pix_addr16;
  logic signed [7:0]  pix_rdata16;
  logic signed [15:0] res_data16;

  logic signed [7:0]  mem   [64];
  logic signed [7:0]  mem16 [64];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dct_coeff_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k1(k1), .k2(k2), .busy(busy),
    .pix_re(pix_re), .pix_addr(pix_addr), .pix_rdata(pix_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  dct_coeff_engine #(.RES_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .k1(3'd0), .k2(3'd0), .busy(busy16),
    .pix_re(pix_re16), .pix_addr(pix_addr16), .pix_rdata(pix_rdata16),
    .res_valid(res_valid16), .res_ready(res_ready16), .res_data(res_data16)
  );

  always @(posedge clk) begin
    if (pix_re)   pix_rdata   <= mem[pix_addr];
    if (pix_re16) pix_rdata16 <= mem16[pix_addr16];
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_c(input int k, input int n);
    real x;
    x = $cos((2.0 * n + 1.0) * k * 3.14159265358979323846 / 16.0) * 32768.0;
    return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(0.5 - x));
  endfunction

  // Integer division truncates toward zero, as the Q8 cos_term requires.
  function automatic longint ref_coef(input int kk1, input int kk2);
    longint s;
    s = 0;
    for (int n1 = 0; n1 < 8; n1++)
      for (int n2 = 0; n2 < 8; n2++)
        s += longint'(mem[n1*8+n2]) * ((ref_c(kk1, n1) * ref_c(kk2, n2)) / 4194304);
    return s;
  endfunction

  task automatic fill(input int v);
    for (int i = 0; i < 64; i++) mem[i] = 8'(v);
  endtask

  // Start a block, optionally poke start mid-RUN, then check latency/result/handshake.
  task automatic do_run(input int kk1, input int kk2, input longint exp,
                        input string tag, input bit poke);
    int cyc;
    @(negedge clk);
    k1 = 3'(kk1); k2 = 3'(kk2); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 200) begin
      @(posedge clk); cyc++; @(negedge clk);
      if (poke && cyc == 10) begin
        k1 = 3'(kk1 ^ 1); k2 = 3'(kk2 ^ 3); start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, cyc, 68);
    check({tag, "_data"}, res_data, exp);
    check({tag, "_busy"}, busy, 1);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic signed [31:0] held;
    int cyc;
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0; k1 = '0; k2 = '0;
    start16 = 1'b0; res_ready16 = 1'b0;
    for (int i = 0; i < 64; i++) begin mem[i] = '0; mem16[i] = 8'sd127; end
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_pix_re", pix_re, 0);
    check("rst_pix_addr", pix_addr, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    fill(1);
    do_run(0, 0, 16384, "ones_k00", 1'b0);
    do_run(7, 5, 0, "ones_k75", 1'b0);
    fill(0); mem[0] = 8'sd1;
    do_run(7, 5, 27, "x00_k75", 1'b0);
    fill(0); mem[3*8+1] = 8'sd1;
    do_run(7, 5, 246, "x31_k75", 1'b0);
    fill(0); mem[3*8+0] = 8'sd2;
    do_run(7, 5, -278, "x30x2_k75", 1'b1);

    for (int t = 0; t < 6; t++) begin
      int rk1, rk2;
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(255));
      rk1 = int'($urandom_range(7));
      rk2 = int'($urandom_range(7));
      do_run(rk1, rk2, ref_coef(rk1, rk2), $sformatf("rand%0d", t), t[0]);
    end

    // Back-pressure: result held 10 cycles, stray starts ignored.
    fill(0); mem[0] = 8'sd1;
    @(negedge clk); k1 = 3'd7; k2 = 3'd5; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 200) begin @(posedge clk); cyc++; @(negedge clk); end
    check("stall_latency", cyc, 68);
    held = res_data;
    check("stall_first", held, 27);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3); k1 = 3'd0; k2 = 3'd0;
      @(posedge clk); @(negedge clk);
      if (i == 9) begin
        check("stall_hold", res_data, held);
        check("stall_busy", busy, 1);
        check("stall_valid", res_valid, 1);
      end else if (res_data !== held || !busy || !res_valid) begin
        check($sformatf("stall_cycle%0d", i), {res_data, busy, res_valid}, {held, 2'b11});
      end
    end
    start = 1'b1; res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; res_ready = 1'b0;
    check("hs_start_ignored", busy, 0);
    do_run(7, 5, 27, "after_stall", 1'b0);

    // Reset while reading address 20.
    fill(3);
    @(negedge clk); k1 = 3'd2; k2 = 3'd1; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(pix_re && pix_addr == 6'd20) && cyc < 100) begin @(posedge clk); cyc++; @(negedge clk); end
    check("addr20_reached", {pix_re, pix_addr}, {1'b1, 6'd20});
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_pix_re", pix_re, 0);
    check("midrst_pix_addr", pix_addr, 0);
    check("midrst_res_data", res_data, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("midrst_no_valid", {busy, res_valid}, 2'b00);
    fill(1);
    do_run(0, 0, 16384, "post_rst", 1'b0);

    // Narrow result path.
    @(negedge clk); start16 = 1'b1;
    @(posedge clk); @(negedge clk); start16 = 1'b0;
    cyc = 0;
    while (!res_valid16 && cyc < 200) begin @(posedge clk); cyc++; @(negedge clk); end
    check("w16_latency", cyc, 68);
`ifdef DCT_RES_SAT_EN
    check("w16_sat", res_data16, 32767);
`else
    check("w16_wrap", res_data16, -16384);
`endif
    res_ready16 = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready16 = 1'b0;
    check("w16_idle", busy16, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dct_coeff_engine.md
Name: dct_coeff_engine

Overview:
- Sequential, parametrised 2D DCT coefficient engine; the generalised successor to the per-(k1,k2) hardwired cosine LUTs.
- For any runtime-selected (k1,k2), it computes the coefficient over an N x N pixel block: F = sum over n1,n2 of x[n1][n2] * cos_term(k1,k2,n1,n2).
- It sits between the block pixel buffer (read port) and the coefficient/quantiser stage (valid/ready output).

Parameters:
- N, 8, block dimension; power of two, 4..16.
- PIX_W, 8, signed pixel width (level-shifted samples).
- C_FRAC, 15, fractional bits of the 1D cosine ROM; entry = round(cos((2n+1)kπ/2N) * 2^C_FRAC), stored as a signed (C_FRAC+2)-bit value.
- OUT_FRAC, 8, fractional bits of the 2D cos_term (Q8 format, same as the legacy tables).
- RES_W, 32, signed result width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; accepted only in IDLE.
- k1  in  $clog2(N)  row frequency; sampled on start accept.
- k2  in  $clog2(N)  column frequency; sampled on start accept.
- busy  out  1  high from start accept until the result is consumed.
- pix_re  out  1  pixel read strobe.
- pix_addr  out  2*$clog2(N)  pixel address {n1,n2}, row-major.
- pix_rdata  in  PIX_W  signed pixel; valid exactly 1 cycle after pix_re.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_data  out  RES_W  signed coefficient F(k1,k2).

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator 0. Reset mid-operation aborts the computation. No stale res_valid after reset.
- States:
  - IDLE: start=1 latches k1/k2, clears the accumulator, sets busy, goes to RUN.
  - RUN: issues N*N reads, one per cycle, n2 innermost, 0..N-1. Moves to DRAIN after address {N-1,N-1}.
  - DRAIN: waits 3 cycles for the pipeline to empty, then goes to DONE.
  - DONE: res_valid=1 with res_data stable until res_valid&&res_ready; then goes to IDLE, busy=0 the following cycle.
- Pipeline, relative to the pix_re cycle:
  - +1: register pix_rdata and cos_term.
  - +2: register the product.
  - +3: accumulate.
- Latency: res_valid rises exactly N*N+4 cycles after the start-accept edge (68 for N=8).
- cos_term = (c(k1,n1) * c(k2,n2)) >>> (2*C_FRAC-OUT_FRAC), truncated toward zero (not floor). With defaults it is bit-identical to the legacy Q8 tables.
- Product: full-width PIX_W x cos_term signed multiply. The accumulator is PIX_W+OUT_FRAC+2+2*$clog2(N) bits wide, so it never overflows internally.
- res_data = accumulator narrowed to RES_W (see the optional feature).
- start while busy: ignored, with no effect on latched k1/k2.
- start in the same cycle as the DONE handshake: ignored; it must be re-asserted in IDLE.

Optional Feature:
- Macro: DCT_RES_SAT_EN.
- Defined: the accumulator saturates to the signed RES_W range when narrowed to res_data.
- Undefined: plain two's-complement truncation (wrap).

Decomposition:
- Shared package dct_pkg holds:
  - default N, PIX_W, C_FRAC, OUT_FRAC;
  - the state enum typedef (IDLE/RUN/DRAIN/DONE);
  - a constant function computing the accumulator width.
- Sub-module dct_cos_1d_rom: combinational N x N ROM indexed by (k,n) with elaboration-time generated entries. It is instantiated twice, for (k1,n1) and (k2,n2).

Test Plan:
- All pixels 1, k=(0,0) -> res_data=16384 (64*256), res_valid at cycle 68 after start accept.
- All pixels 1, k=(7,5) -> res_data=0 (the antisymmetric terms cancel exactly).
- Single nonzero pixel:
  - x[0][0]=1, k=(7,5) -> 27 (0x1b).
  - x[3][1]=1, k=(7,5) -> 246 (0xf6).
  - x[3][0]=2, k=(7,5) -> -278.
- res_ready held low 10 cycles after res_valid -> res_data stable and busy high throughout. A start pulse during that window is ignored. The next start after return to IDLE is accepted.
- rst_n asserted during RUN at address 20 -> outputs 0 immediately, state IDLE. A fresh all-ones k=(0,0) run returns 16384.
- RES_W=16, all pixels 127, k=(0,0) -> 32767 with DCT_RES_SAT_EN defined, -16384 (wrap) without.
